// File: rtl/counter_pkg.sv
// Shared types and constants for the press-counter monitor.
// Holds the FSM state encoding, the sample width and the default sizing.
package counter_pkg;

    localparam int CNT_W          = 3;
    localparam int DEF_HIST_DEPTH = 4;
    localparam int DEF_LAP_W      = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TRACK  = 2'd1,
        S_ERR    = 2'd2,
        S_UNUSED = 2'd3
    } state_t;

    function automatic logic [7:0] onehot8(input logic [CNT_W-1:0] v);
        onehot8 = 8'b0000_0001 << v;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that stops at all-ones; cleared synchronously or by async reset.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clear,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    localparam logic [W-1:0] MAX_VAL = '1;
    localparam logic [W-1:0] ONE     = W'(1);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != MAX_VAL)) begin
            r_count <= r_count + ONE;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/counter_monitor.sv
// Watches a 3-bit press counter: decodes the latest sample, keeps a short
// history, counts 7->0 laps and latches a sticky error on any bad step.
module counter_monitor
    import counter_pkg::*;
#(
    parameter int HIST_DEPTH = DEF_HIST_DEPTH,
    parameter int LAP_W      = DEF_LAP_W
) (
    input  logic                        i_btn_clk,
    input  logic                        i_reset,
    input  logic [CNT_W-1:0]            i_counter,
    input  logic                        i_clear,
    output logic [7:0]                  o_led,
    output logic [LAP_W-1:0]            o_lap,
    output logic                        o_wrap,
    output logic                        o_err,
    output logic [1:0]                  o_state,
    output logic [CNT_W*HIST_DEPTH-1:0] o_hist,
    output logic [3:0]                  o_hist_cnt
);

    localparam int                HIST_W   = CNT_W * HIST_DEPTH;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_ZERO = '0;
    localparam logic [3:0]        HIST_MAX = 4'(HIST_DEPTH);
    localparam logic [3:0]        HC_ONE   = 4'd1;

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_sample;
    logic [7:0]          r_led;
    logic                r_wrap;
    logic                r_err;
    logic [HIST_W-1:0]   r_hist;
    logic [3:0]          r_hist_cnt;

    logic                w_wrap_next;
    logic                w_err_next;
    logic                w_lap_inc;
    logic [CNT_W-1:0]    w_expect;

    assign w_expect = r_sample + CNT_ONE;

    always_ff @(posedge i_btn_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Clear wins in every state; encoding 3 falls back to idle.
    always_comb begin
        w_state_next = r_state;
        w_wrap_next  = 1'b0;
        w_err_next   = r_err;
        w_lap_inc    = 1'b0;
        if (i_clear) begin
            w_state_next = S_IDLE;
            w_err_next   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_next = S_TRACK;
                end
                S_TRACK: begin
                    if (i_counter == w_expect) begin
                        if ((r_sample == CNT_MAX) && (i_counter == CNT_ZERO)) begin
                            w_wrap_next = 1'b1;
                            w_lap_inc   = 1'b1;
                        end
                    end else begin
                        w_state_next = S_ERR;
                        w_err_next   = 1'b1;
                    end
                end
                S_ERR: begin
                    w_state_next = S_ERR;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // The sample and LED decode update on every edge, clear included.
    always_ff @(posedge i_btn_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sample   <= '0;
            r_led      <= 8'b0000_0001;
            r_wrap     <= 1'b0;
            r_err      <= 1'b0;
            r_hist     <= '0;
            r_hist_cnt <= '0;
        end else begin
            r_sample <= i_counter;
            r_led    <= onehot8(i_counter);
            r_wrap   <= w_wrap_next;
            r_err    <= w_err_next;
            if (i_clear) begin
                r_hist     <= '0;
                r_hist_cnt <= '0;
            end else begin
                r_hist <= {r_hist[HIST_W-CNT_W-1:0], i_counter};
                if (r_hist_cnt != HIST_MAX) begin
                    r_hist_cnt <= r_hist_cnt + HC_ONE;
                end
            end
        end
    end

    sat_counter #(
        .W (LAP_W)
    ) u_lap (
        .i_clk   (i_btn_clk),
        .i_reset (i_reset),
        .i_clear (i_clear),
        .i_inc   (w_lap_inc),
        .o_count (o_lap)
    );

    assign o_led      = r_led;
    assign o_wrap     = r_wrap;
    assign o_err      = r_err;
    assign o_state    = r_state;
    assign o_hist     = r_hist;
    assign o_hist_cnt = r_hist_cnt;

endmodule

// File: tb/tb_counter_monitor.sv
// Bench for counter_monitor: a vector table for the main sequences plus
// hand-written reset, saturation and reset-on-edge sequences.
module tb_counter_monitor;

    typedef struct packed {
        logic [7:0]  led;
        logic [3:0]  lap;
        logic        wrap;
        logic        err;
        logic [1:0]  st;
        logic [11:0] hist;
        logic [3:0]  hc;
    } exp_t;

    typedef struct {
        logic [2:0] cnt;
        logic       clr;
        exp_t       e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [2:0]  cnt;
    logic [7:0]  o_led;
    logic [3:0]  o_lap;
    logic        o_wrap;
    logic        o_err;
    logic [1:0]  o_state;
    logic [11:0] o_hist;
    logic [3:0]  o_hist_cnt;

    int   n_checks = 0;
    int   n_err    = 0;
    exp_t exp_q[$];
    vec_t vecs[19];
    exp_t rst_e;

    counter_monitor dut (
        .i_btn_clk  (clk),
        .i_reset    (rst),
        .i_counter  (cnt),
        .i_clear    (clr),
        .o_led      (o_led),
        .o_lap      (o_lap),
        .o_wrap     (o_wrap),
        .o_err      (o_err),
        .o_state    (o_state),
        .o_hist     (o_hist),
        .o_hist_cnt (o_hist_cnt)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [7:0] led, input logic [3:0] lap,
                                input logic wrap, input logic err,
                                input logic [1:0] st, input logic [11:0] hist,
                                input logic [3:0] hc);
        exp_t e;
        e.led = led; e.lap = lap; e.wrap = wrap; e.err = err;
        e.st = st; e.hist = hist; e.hc = hc;
        return e;
    endfunction

    function automatic vec_t mkv(input logic [2:0] c, input logic cl, input exp_t e);
        vec_t v;
        v.cnt = c; v.clr = cl; v.e = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input exp_t e);
        check({tag, ".led"},  32'(o_led),      32'(e.led));
        check({tag, ".lap"},  32'(o_lap),      32'(e.lap));
        check({tag, ".wrap"}, 32'(o_wrap),     32'(e.wrap));
        check({tag, ".err"},  32'(o_err),      32'(e.err));
        check({tag, ".st"},   32'(o_state),    32'(e.st));
        check({tag, ".hist"}, 32'(o_hist),     32'(e.hist));
        check({tag, ".hc"},   32'(o_hist_cnt), 32'(e.hc));
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic press(input logic [2:0] c, input logic cl, input exp_t e, input string tag);
        exp_t got;
        cnt = c;
        clr = cl;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            got = exp_q.pop_front();
            check_out(tag, got);
        end
        @(negedge clk);
    endtask

    initial begin
        bit         have_ref;
        logic [2:0] prev;
        logic [3:0] lap_m;
        logic [11:0] h_m;
        logic [3:0] hc_m;
        logic       wrap_m;

        rst_e = mk(8'h01, 4'd0, 1'b0, 1'b0, 2'd0, 12'h000, 4'd0);

        vecs[0]  = mkv(3'd0, 1'b0, mk(8'h01, 4'd0, 1'b0, 1'b0, 2'd1, 12'h000, 4'd1));
        vecs[1]  = mkv(3'd1, 1'b0, mk(8'h02, 4'd0, 1'b0, 1'b0, 2'd1, 12'h001, 4'd2));
        vecs[2]  = mkv(3'd2, 1'b0, mk(8'h04, 4'd0, 1'b0, 1'b0, 2'd1, 12'h00A, 4'd3));
        vecs[3]  = mkv(3'd4, 1'b1, mk(8'h10, 4'd0, 1'b0, 1'b0, 2'd0, 12'h000, 4'd0));
        vecs[4]  = mkv(3'd5, 1'b0, mk(8'h20, 4'd0, 1'b0, 1'b0, 2'd1, 12'h005, 4'd1));
        vecs[5]  = mkv(3'd6, 1'b0, mk(8'h40, 4'd0, 1'b0, 1'b0, 2'd1, 12'h02E, 4'd2));
        vecs[6]  = mkv(3'd7, 1'b0, mk(8'h80, 4'd0, 1'b0, 1'b0, 2'd1, 12'h177, 4'd3));
        vecs[7]  = mkv(3'd0, 1'b0, mk(8'h01, 4'd1, 1'b1, 1'b0, 2'd1, 12'hBB8, 4'd4));
        vecs[8]  = mkv(3'd1, 1'b0, mk(8'h02, 4'd1, 1'b0, 1'b0, 2'd1, 12'hDC1, 4'd4));
        vecs[9]  = mkv(3'd2, 1'b0, mk(8'h04, 4'd1, 1'b0, 1'b0, 2'd1, 12'hE0A, 4'd4));
        vecs[10] = mkv(3'd3, 1'b0, mk(8'h08, 4'd1, 1'b0, 1'b0, 2'd1, 12'h053, 4'd4));
        vecs[11] = mkv(3'd5, 1'b0, mk(8'h20, 4'd1, 1'b0, 1'b1, 2'd2, 12'h29D, 4'd4));
        vecs[12] = mkv(3'd6, 1'b0, mk(8'h40, 4'd1, 1'b0, 1'b1, 2'd2, 12'h4EE, 4'd4));
        vecs[13] = mkv(3'd7, 1'b0, mk(8'h80, 4'd1, 1'b0, 1'b1, 2'd2, 12'h777, 4'd4));
        vecs[14] = mkv(3'd0, 1'b0, mk(8'h01, 4'd1, 1'b0, 1'b1, 2'd2, 12'hBB8, 4'd4));
        vecs[15] = mkv(3'd4, 1'b1, mk(8'h10, 4'd0, 1'b0, 1'b0, 2'd0, 12'h000, 4'd0));
        vecs[16] = mkv(3'd1, 1'b0, mk(8'h02, 4'd0, 1'b0, 1'b0, 2'd1, 12'h001, 4'd1));
        vecs[17] = mkv(3'd2, 1'b0, mk(8'h04, 4'd0, 1'b0, 1'b0, 2'd1, 12'h00A, 4'd2));
        vecs[18] = mkv(3'd2, 1'b0, mk(8'h04, 4'd0, 1'b0, 1'b1, 2'd2, 12'h052, 4'd3));

        // Clock and reset.
        rst = 1'b0;
        clr = 1'b0;
        cnt = 3'd0;
        #1 rst = 1'b1;
        #1 check_out("reset0", rst_e);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            press(vecs[i].cnt, vecs[i].clr, vecs[i].e, $sformatf("vec%0d", i));
        end

        // Async reset from the error state, checked before any edge.
        #3 rst = 1'b1;
        #1 check_out("rst_err", rst_e);
        @(negedge clk);
        rst = 1'b0;

        // 17 full 0..7 cycles: lap count must stop at 15.
        have_ref = 1'b0;
        prev     = 3'd0;
        lap_m    = 4'd0;
        h_m      = 12'h000;
        hc_m     = 4'd0;
        for (int k = 0; k < 17; k++) begin
            for (int c = 0; c < 8; c++) begin
                wrap_m = have_ref && (prev == 3'd7) && (c == 0);
                if (wrap_m && (lap_m != 4'd15)) lap_m = lap_m + 4'd1;
                h_m = {h_m[8:0], 3'(c)};
                if (hc_m != 4'd4) hc_m = hc_m + 4'd1;
                have_ref = 1'b1;
                prev = 3'(c);
                press(3'(c), 1'b0,
                      mk(8'h01 << c, lap_m, wrap_m, 1'b0, 2'd1, h_m, hc_m),
                      $sformatf("sat%0d_%0d", k, c));
            end
        end
        check("lap_saturated", 32'(o_lap), 32'd15);

        // Reset asserted between edges, mid-press.
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_out("rst_mid", rst_e);
        @(negedge clk);
        rst = 1'b0;
        cnt = 3'd6;
        press(3'd6, 1'b0, mk(8'h40, 4'd0, 1'b0, 1'b0, 2'd1, 12'h006, 4'd1), "mid_ref");

        // Reset held across an edge: no capture of the presented value.
        cnt = 3'd3;
        #4 rst = 1'b1;
        @(posedge clk);
        #1 check_out("rst_edge", rst_e);
        @(negedge clk);
        rst = 1'b0;
        press(3'd5, 1'b0, mk(8'h20, 4'd0, 1'b0, 1'b0, 2'd1, 12'h005, 4'd1), "post_ref");
        press(3'd7, 1'b0, mk(8'h80, 4'd0, 1'b0, 1'b1, 2'd2, 12'h02F, 4'd2), "post_skip");

        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/counter_monitor.md
COUNTER_MONITOR -- requirements
Module: counter_monitor

Interface
REQ-001 Parameter HIST_DEPTH, default 4: number of counter samples retained in history, range 2..8.
REQ-002 Parameter LAP_W, default 4: width of lap (wrap-around) counter.
REQ-003 i_btn_clk  input  1  clock; rising edge = one button press; the sole clock of the block.
REQ-004 i_reset  input  1  reset, asynchronous, active-high.
REQ-005 i_counter  input  3  value from the upstream 3-bit press counter, sampled on each i_btn_clk rising edge.
REQ-006 i_clear  input  1  synchronous clear/re-arm request, sampled on i_btn_clk rising edge.
REQ-007 o_led  output  8  one-hot decode of last captured sample (bit n high when sample == n).
REQ-008 o_lap  output  LAP_W  number of 7->0 wraps seen since reset/clear, saturating.
REQ-009 o_wrap  output  1  high for exactly the one press period in which a 7->0 step was captured.
REQ-010 o_err  output  1  sticky sequence-error flag.
REQ-011 o_state  output  2  FSM state encoding for debug/display.
REQ-012 o_hist  output  3*HIST_DEPTH  sample history, newest in bits [2:0].
REQ-013 o_hist_cnt  output  4  count of valid history entries, saturating at HIST_DEPTH.

Function
REQ-014 Every edge SHALL capture i_counter into a sample register; o_led SHALL reflect it one edge later (latency 1 press).
REQ-015 Captured value is the upstream value before that same edge; the valid progression between consecutive samples SHALL be prev+1 mod 8.
REQ-016 FSM states SHALL be S_IDLE=0 (no reference sample), S_TRACK=1, S_ERR=2; encoding 3 unused and SHALL recover to S_IDLE.
REQ-017 S_IDLE: next edge captures reference sample without checking, goes to S_TRACK.
REQ-018 S_TRACK: sample == prev+1 mod 8 stays; sample == prev or any other skip goes to S_ERR and sets o_err.
REQ-019 S_TRACK, prev==7 and sample==0: o_wrap=1 for that period, o_lap increments; o_lap SHALL hold at 2^LAP_W-1 once reached (no wrap).
REQ-020 S_ERR: o_lap frozen, o_wrap 0, o_err held; history and o_led keep updating.
REQ-021 i_clear high at an edge SHALL have priority in every state: go to S_IDLE, o_lap=0, o_wrap=0, o_err=0, history zeroed, o_hist_cnt=0; that edge's sample SHALL NOT enter history.
REQ-022 History SHALL shift one entry per non-clear edge, oldest discarded; o_hist_cnt increments to HIST_DEPTH then holds.
REQ-023 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-024 i_reset SHALL immediately, without a clock, force S_IDLE, o_led=8'b0000_0001, o_lap=0, o_wrap=0, o_err=0, o_hist=0, o_hist_cnt=0.
REQ-025 Reset mid-sequence SHALL discard all history; first edge after release is treated as an S_IDLE reference capture.
REQ-026 Reset asserted simultaneously with an edge SHALL win; no capture occurs.

Structure
REQ-027 Shared package counter_pkg SHALL hold the FSM state constants, CNT_W=3, and default HIST_DEPTH/LAP_W.
REQ-028 One sub-module, sat_counter (parameterised width, increment, synchronous clear, saturate), SHALL implement o_lap; FSM, decoder and history reside in counter_monitor.

Verification
REQ-029 Reset, then samples 0,1,2 -> S_TRACK, o_led=8'b0000_0100, o_err=0, o_hist=...,2,1,0, o_hist_cnt=3.
REQ-030 Samples 5,6,7,0,1 -> o_wrap=1 only in the period after 0 captured, o_lap=1.
REQ-031 Samples 2,3,5 -> S_ERR, o_err=1; further 6,7,0 -> o_lap unchanged, o_wrap stays 0.
REQ-032 In S_ERR assert i_clear with sample 4 -> S_IDLE, o_err=0, o_lap=0, o_hist_cnt=0; next sample 1 -> S_TRACK without error.
REQ-033 Drive 17 full 0..7 cycles with LAP_W=4 -> o_lap saturates at 15; asynchronous reset mid-press -> all outputs at REQ-024 values before next edge.
